// File: rtl/top_pkg.sv
// rtl/top_pkg.sv - shared CSI lane count and lane data/valid types
package top_pkg;
  localparam int NUM_LANE = 2;
  typedef logic [NUM_LANE*8-1:0] lane_data_t;
  typedef logic [NUM_LANE-1:0]   lane_vld_t;
endpackage

// File: rtl/csi_tx_align_word.sv
// rtl/csi_tx_align_word.sv - CSI-2 TX word framer: HS-prepare, 0xB8 sync, payload, HS-trail, LP gap
//
// Ports:
//   byte_clock, reset (sync, active-high)
//   enable        - gates packet start only
//   pkt_valid_in / word_in / word_last_in / byte_en_last / ready_out - packet word stream
//   hs_req_out    - lanes in HS mode (prepare through trail)
//   word_out / valid_out - per-lane byte and valid to the serializers
//   underrun_out  - 1-cycle pulse when pkt_valid_in drops mid-packet
//   busy_out      - framer not idle
//   skew_taps     - (CSI_TX_SKEW_INJECT_EN only) per-lane output delay 0..2 cycles
//
// Optional feature macro: CSI_TX_SKEW_INJECT_EN
// Output registers are loaded from the state held during the previous cycle,
// so each output cycle shows what the state machine did one cycle earlier.
module csi_tx_align_word
  import top_pkg::*;
#(
  parameter int HS_PREP   = 3,
  parameter int TRAIL_LEN = 2,
  parameter int LP_GAP    = 4
) (
  input  logic                    byte_clock,
  input  logic                    reset,
`ifdef CSI_TX_SKEW_INJECT_EN
  input  logic [NUM_LANE*2-1:0]   skew_taps,
`endif
  input  logic                    enable,
  input  logic                    pkt_valid_in,
  input  lane_data_t              word_in,
  input  logic                    word_last_in,
  input  logic [NUM_LANE-1:0]     byte_en_last,
  output logic                    ready_out,
  output logic                    hs_req_out,
  output lane_data_t              word_out,
  output lane_vld_t               valid_out,
  output logic                    underrun_out,
  output logic                    busy_out
);

  localparam int PW = $clog2(HS_PREP + 1);
  localparam int TW = $clog2(TRAIL_LEN + 1);
  localparam int GW = $clog2(LP_GAP + 1);

  typedef enum logic [2:0] {S_IDLE, S_PREP, S_SYNC, S_DATA, S_TRAIL, S_GAP} state_t;

  state_t              state_q, state_d;
  logic [PW-1:0]       prep_cnt_q, prep_cnt_d;
  logic [TW-1:0]       trail_cnt_q, trail_cnt_d;
  logic [GW-1:0]       gap_cnt_q, gap_cnt_d;
  lane_vld_t           last_msb_q, last_msb_d;   // MSB of last byte sent per lane
  lane_data_t          word_q, word_d;
  lane_vld_t           vld_q, vld_d;
  logic                hs_q, hs_d;
  logic                underrun_q, underrun_d;
  logic                busy_q, busy_d;

  assign ready_out    = (state_q == S_DATA);
  assign underrun_out = underrun_q;
  assign busy_out     = busy_q;

  always_comb begin
    state_d     = state_q;
    prep_cnt_d  = prep_cnt_q;
    trail_cnt_d = trail_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    last_msb_d  = last_msb_q;
    word_d      = '0;
    vld_d       = '0;
    hs_d        = 1'b0;
    underrun_d  = 1'b0;
    busy_d      = (state_q != S_IDLE);
    case (state_q)
      S_IDLE: begin
        if (enable && pkt_valid_in) begin
          state_d    = S_PREP;
          prep_cnt_d = PW'(HS_PREP - 1);
        end
      end
      S_PREP: begin
        hs_d = 1'b1;
        if (prep_cnt_q == '0) state_d = S_SYNC;
        else                  prep_cnt_d = prep_cnt_q - 1'b1;
      end
      S_SYNC: begin
        hs_d       = 1'b1;
        word_d     = {NUM_LANE{8'hB8}};
        vld_d      = '1;
        last_msb_d = '1;    // sync byte 0xB8 has MSB set
        state_d    = S_DATA;
      end
      S_DATA: begin
        hs_d = 1'b1;
        if (!pkt_valid_in) begin
          underrun_d  = 1'b1;
          state_d     = S_TRAIL;
          trail_cnt_d = TW'(TRAIL_LEN);
        end else begin
          vld_d = '1;
          for (int i = 0; i < NUM_LANE; i++) begin
            if (!word_last_in || byte_en_last[i]) begin
              word_d[i*8 +: 8] = word_in[i*8 +: 8];
              last_msb_d[i]    = word_in[i*8 + 7];
            end else begin
              // lane without payload on the last word starts its trail now
              word_d[i*8 +: 8] = {8{~last_msb_q[i]}};
            end
          end
          if (word_last_in) begin
            state_d     = S_TRAIL;
            trail_cnt_d = TW'(TRAIL_LEN);
          end
        end
      end
      S_TRAIL: begin
        hs_d = 1'b1;
        // TRAIL_LEN trail bytes, then one HS-exit cycle with lanes idle
        if (trail_cnt_q != '0) begin
          vld_d = '1;
          for (int i = 0; i < NUM_LANE; i++) word_d[i*8 +: 8] = {8{~last_msb_q[i]}};
          trail_cnt_d = trail_cnt_q - 1'b1;
        end else begin
          state_d   = S_GAP;
          gap_cnt_d = GW'(LP_GAP - 1);
        end
      end
      S_GAP: begin
        if (gap_cnt_q == '0) state_d = S_IDLE;
        else                 gap_cnt_d = gap_cnt_q - 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge byte_clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      prep_cnt_q  <= '0;
      trail_cnt_q <= '0;
      gap_cnt_q   <= '0;
      last_msb_q  <= '0;
      word_q      <= '0;
      vld_q       <= '0;
      hs_q        <= 1'b0;
      underrun_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      prep_cnt_q  <= prep_cnt_d;
      trail_cnt_q <= trail_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      last_msb_q  <= last_msb_d;
      word_q      <= word_d;
      vld_q       <= vld_d;
      hs_q        <= hs_d;
      underrun_q  <= underrun_d;
      busy_q      <= busy_d;
    end
  end

`ifdef CSI_TX_SKEW_INJECT_EN
  logic [NUM_LANE*2-1:0] taps_q, taps_d;
  lane_data_t            word_p1_q, word_p2_q;
  lane_vld_t             vld_p1_q, vld_p2_q;
  logic                  hs_p1_q, hs_p2_q;
  logic [1:0]            max_tap;

  always_comb begin
    taps_d = taps_q;
    if (state_q == S_IDLE && enable && pkt_valid_in) begin
      for (int i = 0; i < NUM_LANE; i++)
        taps_d[i*2 +: 2] = (skew_taps[i*2 +: 2] == 2'd3) ? 2'd2 : skew_taps[i*2 +: 2];
    end
  end

  always_ff @(posedge byte_clock) begin
    if (reset) begin
      taps_q    <= '0;
      word_p1_q <= '0;
      word_p2_q <= '0;
      vld_p1_q  <= '0;
      vld_p2_q  <= '0;
      hs_p1_q   <= 1'b0;
      hs_p2_q   <= 1'b0;
    end else begin
      taps_q    <= taps_d;
      word_p1_q <= word_q;
      word_p2_q <= word_p1_q;
      vld_p1_q  <= vld_q;
      vld_p2_q  <= vld_p1_q;
      hs_p1_q   <= hs_q;
      hs_p2_q   <= hs_p1_q;
    end
  end

  always_comb begin
    word_out  = '0;
    valid_out = '0;
    max_tap   = 2'd0;
    for (int i = 0; i < NUM_LANE; i++) begin
      case (taps_q[i*2 +: 2])
        2'd0: begin word_out[i*8 +: 8] = word_q[i*8 +: 8];    valid_out[i] = vld_q[i];    end
        2'd1: begin word_out[i*8 +: 8] = word_p1_q[i*8 +: 8]; valid_out[i] = vld_p1_q[i]; end
        default: begin word_out[i*8 +: 8] = word_p2_q[i*8 +: 8]; valid_out[i] = vld_p2_q[i]; end
      endcase
      if (taps_q[i*2 +: 2] > max_tap) max_tap = taps_q[i*2 +: 2];
    end
    // keep HS mode up until the most-delayed lane has drained its trail
    hs_req_out = hs_q | ((max_tap != 2'd0) & hs_p1_q) | ((max_tap == 2'd2) & hs_p2_q);
  end
`else
  assign word_out   = word_q;
  assign valid_out  = vld_q;
  assign hs_req_out = hs_q;
`endif

endmodule
